// File: rtl/grf_wb_queue_pkg.sv
// Shared widths, the zero-register constant and the queue entry layout for the
// register-file write-back initiator.
package grf_wb_queue_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;
    localparam int WB_PC_W   = 32;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic [WB_PC_W-1:0]   pc;
    } wb_entry_t;

    localparam wb_entry_t ENTRY_NULL = {$bits(wb_entry_t){1'b0}};

    // Register $0 is hard-wired, so it never produces a read hazard.
    function automatic logic addr_hit(input logic [WB_ADDR_W-1:0] entry_addr,
                                      input logic [WB_ADDR_W-1:0] read_addr);
        return (read_addr != REG_ZERO) && (entry_addr == read_addr);
    endfunction

endpackage

// File: rtl/grf_wb_fifo.sv
// In-order storage for secondary write-backs: entry array, head/tail pointers,
// occupancy count, per-entry WAW squash and decode read-hazard match.
module grf_wb_fifo
    import grf_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WB_ADDR_W-1:0]   push_addr_i,
    input  logic [WB_DATA_W-1:0]   push_data_i,
    input  logic [WB_PC_W-1:0]     push_pc_i,
    input  logic                   pop_i,
    input  logic                   squash_i,
    input  logic [WB_ADDR_W-1:0]   squash_addr_i,
    input  logic [WB_ADDR_W-1:0]   chk_a1_i,
    input  logic [WB_ADDR_W-1:0]   chk_a2_i,
    output wb_entry_t              head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_s;

    // Next-state: squash matching entries, retire the head, append at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]       = mem_q[i];
            mem_d[i].valid = mem_q[i].valid &
                             ~(squash_i && (mem_q[i].addr == squash_addr_i));
        end
        if (pop_i) begin
            mem_d[head_q].valid = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        // A push never lands on the slot being popped: push requires not-full.
        if (push_i) begin
            mem_d[tail_q] = '{valid: 1'b1, addr: push_addr_i,
                              data: push_data_i, pc: push_pc_i};
            tail_d        = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset drops every queued write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ENTRY_NULL;
            end
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Read-hazard match over live entries only; holes never stall decode.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_s = busy_s | (mem_q[i].valid &
                     (addr_hit(mem_q[i].addr, chk_a1_i) |
                      addr_hit(mem_q[i].addr, chk_a2_i)));
        end
    end

    assign head_o  = mem_q[head_q];
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign busy_o  = busy_s;

endmodule

// File: rtl/grf_wb_queue.sv
// Register-file write-port initiator: primary results win, queued secondary
// results fill idle cycles. Optional same-cycle bypass: WB_QUEUE_BYPASS_EN.
module grf_wb_queue
    import grf_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pri_we_i,
    input  logic [4:0]             pri_addr_i,
    input  logic [31:0]            pri_data_i,
    input  logic [31:0]            pri_pc_i,
    input  logic                   sec_valid_i,
    output logic                   sec_ready_o,
    input  logic [4:0]             sec_addr_i,
    input  logic [31:0]            sec_data_i,
    input  logic [31:0]            sec_pc_i,
    output logic                   grf_we_o,
    output logic [4:0]             grf_addr_o,
    output logic [31:0]            grf_data_o,
    output logic [31:0]            grf_pc_o,
    input  logic [4:0]             chk_a1_i,
    input  logic [4:0]             chk_a2_i,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] count_o
);

    logic      pri_live_s;
    logic      accept_s;
    logic      sec_nz_s;
    logic      waw_drop_s;
    logic      bypass_s;
    logic      push_s;
    logic      pop_s;
    logic      empty_s;
    logic      full_s;
    wb_entry_t head_s;

    assign pri_live_s = pri_we_i && (pri_addr_i != REG_ZERO);

    // Readiness looks only at registered occupancy, so a full queue refuses
    // a push even in a cycle where the head drains.
    assign sec_ready_o = rst_ni && !full_s;
    assign accept_s    = sec_valid_i && sec_ready_o;
    assign sec_nz_s    = (sec_addr_i != REG_ZERO);
    assign waw_drop_s  = pri_live_s && (sec_addr_i == pri_addr_i);

`ifdef WB_QUEUE_BYPASS_EN
    assign bypass_s = accept_s && sec_nz_s && empty_s && !pri_live_s;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s = accept_s && sec_nz_s && !waw_drop_s && !bypass_s;
    assign pop_s  = !pri_live_s && !empty_s;

    grf_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (push_s),
        .push_addr_i   (sec_addr_i),
        .push_data_i   (sec_data_i),
        .push_pc_i     (sec_pc_i),
        .pop_i         (pop_s),
        .squash_i      (pri_live_s),
        .squash_addr_i (pri_addr_i),
        .chk_a1_i      (chk_a1_i),
        .chk_a2_i      (chk_a2_i),
        .head_o        (head_s),
        .empty_o       (empty_s),
        .full_o        (full_s),
        .count_o       (count_o),
        .busy_o        (busy_o)
    );

    // Write-port source select: primary, then bypassed secondary, then head.
    always_comb begin
        if (!rst_ni) begin
            grf_we_o   = 1'b0;
            grf_addr_o = REG_ZERO;
            grf_data_o = {WB_DATA_W{1'b0}};
            grf_pc_o   = {WB_PC_W{1'b0}};
        end else if (pri_live_s) begin
            grf_we_o   = 1'b1;
            grf_addr_o = pri_addr_i;
            grf_data_o = pri_data_i;
            grf_pc_o   = pri_pc_i;
        end else if (bypass_s) begin
            grf_we_o   = 1'b1;
            grf_addr_o = sec_addr_i;
            grf_data_o = sec_data_i;
            grf_pc_o   = sec_pc_i;
        end else if (!empty_s) begin
            grf_we_o   = head_s.valid;
            grf_addr_o = head_s.addr;
            grf_data_o = head_s.data;
            grf_pc_o   = head_s.pc;
        end else begin
            grf_we_o   = 1'b0;
            grf_addr_o = REG_ZERO;
            grf_data_o = {WB_DATA_W{1'b0}};
            grf_pc_o   = {WB_PC_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_grf_wb_queue.sv
// Self-checking bench for grf_wb_queue: a queue model acts as scoreboard, each
// scenario task adds its own directed checks.
`timescale 1ns/1ps
module tb_grf_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pri_we;
    logic [4:0]  pri_addr;
    logic [31:0] pri_data;
    logic [31:0] pri_pc;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_addr;
    logic [31:0] sec_data;
    logic [31:0] sec_pc;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_data;
    logic [31:0] grf_pc;
    logic [4:0]  chk_a1;
    logic [4:0]  chk_a2;
    logic        busy;
    logic [2:0]  count;

    typedef struct {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    grf_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .pri_we_i(pri_we), .pri_addr_i(pri_addr), .pri_data_i(pri_data), .pri_pc_i(pri_pc),
        .sec_valid_i(sec_valid), .sec_ready_o(sec_ready),
        .sec_addr_i(sec_addr), .sec_data_i(sec_data), .sec_pc_i(sec_pc),
        .grf_we_o(grf_we), .grf_addr_o(grf_addr), .grf_data_o(grf_data), .grf_pc_o(grf_pc),
        .chk_a1_i(chk_a1), .chk_a2_i(chk_a2), .busy_o(busy), .count_o(count)
    );

    task automatic set_pri(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        pri_we = we; pri_addr = a; pri_data = d; pri_pc = p;
    endtask

    task automatic set_sec(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        sec_valid = v; sec_addr = a; sec_data = d; sec_pc = p;
    endtask

    task automatic idle();
        set_pri(1'b0, 5'd0, 32'd0, 32'd0);
        set_sec(1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    // One clock: compare outputs against the scoreboard, then advance it at the edge.
    task automatic tick();
        logic        pri_live, exp_ready, accept, byp, exp_we, exp_busy, cmp_fields;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data, exp_pc;
        exp_t        e;
        #1;
        pri_live  = pri_we && (pri_addr != 5'd0);
        exp_ready = (sb.size() < DEPTH);
        accept    = sec_valid && exp_ready;
        byp       = 1'b0;
`ifdef WB_QUEUE_BYPASS_EN
        byp = accept && (sec_addr != 5'd0) && (sb.size() == 0) && !pri_live;
`endif
        cmp_fields = 1'b1;
        if (pri_live) begin
            exp_we = 1'b1; exp_addr = pri_addr; exp_data = pri_data; exp_pc = pri_pc;
        end else if (byp) begin
            exp_we = 1'b1; exp_addr = sec_addr; exp_data = sec_data; exp_pc = sec_pc;
        end else if (sb.size() > 0) begin
            exp_we = sb[0].valid; exp_addr = sb[0].addr; exp_data = sb[0].data; exp_pc = sb[0].pc;
            cmp_fields = sb[0].valid;
        end else begin
            exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_pc = 32'd0;
        end
        exp_busy = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].valid && (((chk_a1 != 5'd0) && (sb[i].addr == chk_a1)) ||
                                ((chk_a2 != 5'd0) && (sb[i].addr == chk_a2))))
                exp_busy = 1'b1;
        end
        total++;
        if (sec_ready !== exp_ready) begin bad++; $display("FAIL sb_ready t=%0t got %b want %b", $time, sec_ready, exp_ready); end
        total++;
        if (grf_we !== exp_we) begin bad++; $display("FAIL sb_we t=%0t got %b want %b", $time, grf_we, exp_we); end
        if (cmp_fields) begin
            total++;
            if ({grf_addr, grf_data, grf_pc} !== {exp_addr, exp_data, exp_pc}) begin
                bad++;
                $display("FAIL sb_payload t=%0t got %0d/%h/%h want %0d/%h/%h", $time,
                         grf_addr, grf_data, grf_pc, exp_addr, exp_data, exp_pc);
            end
        end
        total++;
        if (busy !== exp_busy) begin bad++; $display("FAIL sb_busy t=%0t got %b want %b", $time, busy, exp_busy); end
        total++;
        if (count !== 3'(sb.size())) begin bad++; $display("FAIL sb_count t=%0t got %0d want %0d", $time, count, sb.size()); end
        @(posedge clk);
        if (pri_live) begin
            foreach (sb[i]) if (sb[i].addr == pri_addr) sb[i].valid = 1'b0;
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
        if (accept && (sec_addr != 5'd0) && !(pri_live && (sec_addr == pri_addr)) && !byp) begin
            e.valid = 1'b1; e.addr = sec_addr; e.data = sec_data; e.pc = sec_pc;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); chk_a1 = 5'd0; chk_a2 = 5'd0;
        #2;
        total++;
        if ({sec_ready, grf_we, busy, count} !== 6'd0) begin
            bad++; $display("FAIL reset_state got rdy=%b we=%b busy=%b cnt=%0d want all 0", sec_ready, grf_we, busy, count);
        end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (sec_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got %b want 1", sec_ready); end
    endtask

    task automatic test_basic_latency();
        set_sec(1'b1, 5'd8, 32'h1234, 32'h3000);
        #1;
        total++;
`ifdef WB_QUEUE_BYPASS_EN
        if ({grf_we, grf_addr, grf_data, grf_pc} !== {1'b1, 5'd8, 32'h1234, 32'h3000}) begin
            bad++; $display("FAIL basic_bypass got %b/%0d/%h want 1/8/1234", grf_we, grf_addr, grf_data);
        end
`else
        if (grf_we !== 1'b0) begin bad++; $display("FAIL basic_same_cycle got we=%b want 0", grf_we); end
`endif
        tick();
        idle();
        #1;
`ifndef WB_QUEUE_BYPASS_EN
        total++;
        if ({grf_we, grf_addr, grf_data, grf_pc} !== {1'b1, 5'd8, 32'h1234, 32'h3000}) begin
            bad++; $display("FAIL basic_next_cycle got %b/%0d/%h/%h want 1/8/1234/3000", grf_we, grf_addr, grf_data, grf_pc);
        end
`endif
        tick();
    endtask

    task automatic test_fill_primary();
        for (int i = 0; i < 4; i++) begin
            set_pri(1'b1, 5'(i + 1), 32'hA000 + 32'(i), 32'h100 + 32'(i));
            set_sec(1'b1, 5'(i + 10), 32'hC000 + 32'(i), 32'h200 + 32'(i));
            tick();
        end
        set_pri(1'b1, 5'd1, 32'hA0FF, 32'h1FF);
        set_sec(1'b1, 5'd14, 32'hDEAD, 32'h2FF);
        #1;
        total++;
        if ({sec_ready, count, grf_addr, grf_data} !== {1'b0, 3'd4, 5'd1, 32'hA0FF}) begin
            bad++; $display("FAIL fill_full got rdy=%b cnt=%0d addr=%0d want 0/4/1", sec_ready, count, grf_addr);
        end
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({grf_we, grf_addr, grf_data} !== {1'b1, 5'(i + 10), 32'hC000 + 32'(i)}) begin
                bad++; $display("FAIL drain_order got %b/%0d/%h want 1/%0d", grf_we, grf_addr, grf_data, i + 10);
            end
            tick();
        end
    endtask

    task automatic test_squash();
        set_pri(1'b1, 5'd1, 32'h1111, 32'h10);
        set_sec(1'b1, 5'd5, 32'hAAAA, 32'h20);
        tick();
        set_pri(1'b1, 5'd5, 32'hBBBB, 32'h30);
        set_sec(1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        idle();
        #1;
        total++;
        if ({grf_we, count} !== {1'b0, 3'd1}) begin
            bad++; $display("FAIL squash_hole got we=%b cnt=%0d want 0/1", grf_we, count);
        end
        tick();
    endtask

    task automatic test_same_addr();
        set_pri(1'b1, 5'd9, 32'h9999, 32'h40);
        set_sec(1'b1, 5'd9, 32'h5555, 32'h50);
        #1;
        total++;
        if ({grf_addr, grf_data} !== {5'd9, 32'h9999}) begin
            bad++; $display("FAIL waw_same_cycle got %0d/%h want 9/9999", grf_addr, grf_data);
        end
        tick();
        idle();
        #1;
        total++;
        if ({grf_we, count} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL waw_discard got we=%b cnt=%0d want 0/0", grf_we, count);
        end
        tick();
    endtask

    task automatic test_busy();
        set_pri(1'b1, 5'd1, 32'h1, 32'h60);
        set_sec(1'b1, 5'd7, 32'h7777, 32'h70);
        tick();
        set_sec(1'b0, 5'd0, 32'd0, 32'd0);
        chk_a1 = 5'd7;
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_a1 got %b want 1", busy); end
        tick();
        chk_a1 = 5'd0; chk_a2 = 5'd7;
        tick();
        idle(); chk_a2 = 5'd0;
        tick();
        set_sec(1'b1, 5'd0, 32'h0BAD, 32'h80);
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_zero got %b want 0", busy); end
        tick();
        idle();
        #1;
        total++;
        if (count !== 3'd0) begin bad++; $display("FAIL zero_not_queued got %0d want 0", count); end
    endtask

    task automatic test_reset_mid_queue();
        for (int i = 0; i < 3; i++) begin
            set_pri(1'b1, 5'd1, 32'h2, 32'h90);
            set_sec(1'b1, 5'(i + 20), 32'hE000 + 32'(i), 32'hA0);
            tick();
        end
        idle(); chk_a1 = 5'd20;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({count, busy, grf_we, sec_ready} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_mid got cnt=%0d busy=%b we=%b rdy=%b want 0/0/0/0", count, busy, grf_we, sec_ready);
        end
        sb.delete();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; chk_a1 = 5'd0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            set_pri(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom, $urandom);
            set_sec(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom, $urandom);
            chk_a1 = 5'($urandom_range(0, 7));
            chk_a2 = 5'($urandom_range(0, 7));
            tick();
        end
        idle();
        for (int n = 0; n < DEPTH + 1; n++) tick();
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_fill_primary();
        test_squash();
        test_same_addr();
        test_busy();
        test_reset_mid_queue();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
